reconf_tile_accum: RTL and testbench

Downstream stage of the reconfigurable mul/adder-tree tile. It consumes the tile's per-chunk FP16 reduction result (o_scal) as a stream of beats and accumulates the beats of one job into a single FP16 dot product. A 1-entry output register with valid/ready hands the result on. This lets vectors longer than tile_size be reduced over several tile passes.

---
 rtl/reconf_pkg.sv | 15 +
 rtl/new_fp16_add.sv | 113 +++++++++++
 rtl/reconf_out_reg.sv | 38 +++
 rtl/reconf_tile_accum.sv | 136 +++++++++++++
 tb/tb_reconf_tile_accum.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/reconf_pkg.sv
// Shared types and FP16 constants for the tile accumulator stage.
package reconf_pkg;

    typedef logic [15:0] fp16_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    localparam fp16_t FP16_ONE      = 16'h3C00;
    localparam fp16_t FP16_QNAN     = 16'h7E00;
    localparam fp16_t FP16_NEG_ZERO = 16'h8000;

endpackage

// File: rtl/new_fp16_add.sv
// Combinational FP16 adder, round-to-nearest-even, subnormal support,
// any NaN operand or inf-inf yields the canonical quiet NaN.
module new_fp16_add (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] sum_o
);
    logic        a_big_s;
    logic [15:0] x_s;
    logic [15:0] y_s;
    logic [4:0]  ex_s;
    logic [4:0]  ey_s;
    logic [4:0]  emax_s;
    logic [13:0] ax_s;
    logic [13:0] ay_s;
    logic [13:0] ay_sh_s;
    logic [4:0]  diff_s;
    logic        sticky_s;
    logic        eff_sub_s;
    logic [14:0] raw_s;
    logic [3:0]  lz_s;
    logic        found_s;
    logic [3:0]  shift_s;
    logic [13:0] norm_s;
    logic [5:0]  exp_n_s;
    logic        round_up_s;
    logic [15:0] packed_s;
    logic        x_nan_s;
    logic        y_nan_s;
    logic        x_inf_s;
    logic        y_inf_s;
    logic        ovf_s;

    // Align, add/subtract, normalise and round in one combinational pass
    always_comb begin
        a_big_s   = (a_i[14:0] >= b_i[14:0]);
        x_s       = a_big_s ? a_i : b_i;
        y_s       = a_big_s ? b_i : a_i;
        ex_s      = (x_s[14:10] == 5'd0) ? 5'd1 : x_s[14:10];
        ey_s      = (y_s[14:10] == 5'd0) ? 5'd1 : y_s[14:10];
        ax_s      = {(x_s[14:10] != 5'd0), x_s[9:0], 3'b000};
        ay_s      = {(y_s[14:10] != 5'd0), y_s[9:0], 3'b000};
        diff_s    = ex_s - ey_s;
        eff_sub_s = x_s[15] ^ y_s[15];

        if (diff_s >= 5'd14) begin
            ay_sh_s  = 14'd0;
            sticky_s = |ay_s;
        end else begin
            ay_sh_s  = ay_s >> diff_s;
            sticky_s = |(ay_s & ~(14'h3FFF << diff_s));
        end
        ay_sh_s[0] = ay_sh_s[0] | sticky_s;

        if (eff_sub_s) begin
            raw_s = {1'b0, ax_s} - {1'b0, ay_sh_s};
        end else begin
            raw_s = {1'b0, ax_s} + {1'b0, ay_sh_s};
        end

        found_s = 1'b0;
        lz_s    = 4'd0;
        for (int i = 13; i >= 0; i--) begin
            if (!found_s) begin
                if (raw_s[i]) begin
                    found_s = 1'b1;
                end else begin
                    lz_s = lz_s + 4'd1;
                end
            end else begin
                found_s = found_s;
            end
        end

        // Left shift is capped so the exponent never drops below the subnormal floor
        emax_s  = ex_s - 5'd1;
        shift_s = 4'd0;
        if (raw_s[14]) begin
            norm_s  = raw_s[14:1] | {13'd0, raw_s[0]};
            exp_n_s = {1'b0, ex_s} + 6'd1;
        end else begin
            if ({1'b0, lz_s} > emax_s) begin
                shift_s = emax_s[3:0];
            end else begin
                shift_s = lz_s;
            end
            norm_s  = raw_s[13:0] << shift_s;
            exp_n_s = norm_s[13] ? ({1'b0, ex_s} - {2'b00, shift_s}) : 6'd0;
        end

        round_up_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
        packed_s   = {1'b0, exp_n_s[4:0], norm_s[12:3]} + {15'd0, round_up_s};
        ovf_s      = exp_n_s[5] | packed_s[15] | (packed_s[14:10] == 5'h1F);

        x_nan_s = (x_s[14:10] == 5'h1F) && (x_s[9:0] != 10'd0);
        y_nan_s = (y_s[14:10] == 5'h1F) && (y_s[9:0] != 10'd0);
        x_inf_s = (x_s[14:10] == 5'h1F) && (x_s[9:0] == 10'd0);
        y_inf_s = (y_s[14:10] == 5'h1F) && (y_s[9:0] == 10'd0);

        if (x_nan_s || y_nan_s || (x_inf_s && y_inf_s && eff_sub_s)) begin
            sum_o = 16'h7E00;
        end else if (x_inf_s) begin
            sum_o = {x_s[15], 5'h1F, 10'd0};
        end else if (raw_s == 15'd0) begin
            sum_o = {x_s[15] & y_s[15], 15'd0};
        end else if (ovf_s) begin
            sum_o = {x_s[15], 5'h1F, 10'd0};
        end else begin
            sum_o = {x_s[15], packed_s[14:0]};
        end
    end

endmodule

// File: rtl/reconf_out_reg.sv
// One-entry valid/ready holding register for a {data, count, ovf} result.
module reconf_out_reg #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CNT_W-1:0]  count_i,
    input  logic              ovf_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              ovf_o
);

    // A load wins over a drain so back-to-back results keep valid high
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            count_o <= '0;
            ovf_o   <= 1'b0;
        end else if (load_i) begin
            valid_o <= 1'b1;
            data_o  <= data_i;
            count_o <= count_i;
            ovf_o   <= ovf_i;
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
        end else begin
            valid_o <= valid_o;
        end
    end

endmodule

// File: rtl/reconf_tile_accum.sv
// Accumulates a stream of FP16 tile partial sums into one dot product per job.
module reconf_tile_accum
    import reconf_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_last_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  out_count_o,
    output logic              out_ovf_o,
    output logic              busy_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_r;
    fp16_t            acc_r;
    logic [CNT_W-1:0] count_r;
    logic             ovf_r;
    fp16_t            sum_s;
    logic             beat_s;
    logic [CNT_W-1:0] count_inc_s;
    logic             ovf_next_s;
    logic             load_s;
    fp16_t            load_data_s;
    logic [CNT_W-1:0] load_count_s;
    logic             load_ovf_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    assign in_ready_o  = !clear_i && (!out_valid_o || out_ready_i);
    assign beat_s      = in_valid_i && in_ready_o;
    assign busy_o      = (state_r == ACCUM);
    assign count_inc_s = sat_inc(count_r);
    assign ovf_next_s  = ovf_r | (count_r == CNT_MAX);

    new_fp16_add u_add (
        .a_i   (acc_r),
        .b_i   (in_data_i),
        .sum_o (sum_s)
    );

    // The first beat of a job bypasses the adder so -0 and NaN payloads survive
    always_comb begin
        load_s       = 1'b0;
        load_data_s  = in_data_i;
        load_count_s = CNT_ONE;
        load_ovf_s   = 1'b0;
        if (beat_s && in_last_i) begin
            load_s = 1'b1;
            if (state_r == ACCUM) begin
                load_data_s  = sum_s;
                load_count_s = count_inc_s;
                load_ovf_s   = ovf_next_s;
            end else begin
                load_data_s  = in_data_i;
                load_count_s = CNT_ONE;
                load_ovf_s   = 1'b0;
            end
        end else begin
            load_s = 1'b0;
        end
    end

    // Job FSM and accumulator state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
            acc_r   <= 16'h0000;
            count_r <= '0;
            ovf_r   <= 1'b0;
        end else if (clear_i) begin
            state_r <= IDLE;
            acc_r   <= 16'h0000;
            count_r <= '0;
            ovf_r   <= 1'b0;
        end else if (beat_s) begin
            case (state_r)
                IDLE: begin
                    if (!in_last_i) begin
                        state_r <= ACCUM;
                        acc_r   <= in_data_i;
                        count_r <= CNT_ONE;
                        ovf_r   <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCUM: begin
                    if (!in_last_i) begin
                        acc_r   <= sum_s;
                        count_r <= count_inc_s;
                        ovf_r   <= ovf_next_s;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

    reconf_out_reg #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_out (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (load_s),
        .data_i  (load_data_s),
        .count_i (load_count_s),
        .ovf_i   (load_ovf_s),
        .ready_i (out_ready_i),
        .valid_o (out_valid_o),
        .data_o  (out_data_o),
        .count_o (out_count_o),
        .ovf_o   (out_ovf_o)
    );

endmodule

// File: tb/tb_reconf_tile_accum.sv
// Directed bench for reconf_tile_accum: job table plus reset/backpressure/clear/saturation sequences.
module tb_reconf_tile_accum;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0000;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic [7:0]  out_count;
    logic        out_ovf;
    logic        busy;

    logic        s_clear = 1'b0;
    logic        s_in_valid = 1'b0;
    logic        s_in_ready;
    logic [15:0] s_in_data = 16'h0000;
    logic        s_in_last = 1'b0;
    logic        s_out_valid;
    logic        s_out_ready = 1'b1;
    logic [15:0] s_out_data;
    logic [1:0]  s_out_count;
    logic        s_out_ovf;
    logic        s_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reconf_tile_accum dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_last_i(in_last),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_count_o(out_count), .out_ovf_o(out_ovf), .busy_o(busy)
    );

    reconf_tile_accum #(.DATA_W(16), .CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(s_clear),
        .in_valid_i(s_in_valid), .in_ready_o(s_in_ready), .in_data_i(s_in_data), .in_last_i(s_in_last),
        .out_valid_o(s_out_valid), .out_ready_i(s_out_ready), .out_data_o(s_out_data),
        .out_count_o(s_out_count), .out_ovf_o(s_out_ovf), .busy_o(s_busy)
    );

    typedef struct {
        string       name;
        int          n;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [15:0] d2;
        logic [15:0] exp_data;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input string name, input int n, input logic [15:0] d0,
                           input logic [15:0] d1, input logic [15:0] d2,
                           input logic [15:0] e, input logic [7:0] c);
        vecs[i].name = name; vecs[i].n = n;
        vecs[i].d0 = d0; vecs[i].d1 = d1; vecs[i].d2 = d2;
        vecs[i].exp_data = e; vecs[i].exp_cnt = c;
    endtask

    // Entered and left at posedge+1; the beat is taken on the enclosed posedge
    task automatic send(input logic [15:0] d, input logic last);
        in_valid = 1'b1; in_data = d; in_last = last;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_sat(input logic [15:0] d, input logic last);
        s_in_valid = 1'b1; s_in_data = d; s_in_last = last;
        @(posedge clk); #1;
        s_in_valid = 1'b0; s_in_last = 1'b0;
    endtask

    initial begin
        logic [15:0] beat;

        set_vec(0,  "three_beat",   3, 16'h3C00, 16'h4000, 16'h4200, 16'h4600, 8'd3);
        set_vec(1,  "neg_zero",     1, 16'h8000, 16'h0000, 16'h0000, 16'h8000, 8'd1);
        set_vec(2,  "nan_payload",  1, 16'h7E01, 16'h0000, 16'h0000, 16'h7E01, 8'd1);
        set_vec(3,  "cancel",       2, 16'h3C00, 16'hBC00, 16'h0000, 16'h0000, 8'd2);
        set_vec(4,  "two_half",     2, 16'h4000, 16'h3800, 16'h0000, 16'h4100, 8'd2);
        set_vec(5,  "plus_inf",     2, 16'h3C00, 16'h7C00, 16'h0000, 16'h7C00, 8'd2);
        set_vec(6,  "inf_minus",    2, 16'h7C00, 16'hFC00, 16'h0000, 16'h7E00, 8'd2);
        set_vec(7,  "tiny_lost",    2, 16'h3C00, 16'h0001, 16'h0000, 16'h3C00, 8'd2);
        set_vec(8,  "subnorm",      2, 16'h0001, 16'h0001, 16'h0000, 16'h0002, 8'd2);
        set_vec(9,  "overflow",     2, 16'h7BFF, 16'h7BFF, 16'h0000, 16'h7C00, 8'd2);
        set_vec(10, "tie_even",     2, 16'h3C00, 16'h1000, 16'h0000, 16'h3C00, 8'd2);
        set_vec(11, "tie_odd",      2, 16'h3C01, 16'h1000, 16'h0000, 16'h3C02, 8'd2);
        set_vec(12, "sub_normlz",   2, 16'h3C00, 16'hBBFF, 16'h0000, 16'h1000, 8'd2);

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_data",  {16'd0, out_data}, 32'd0);
        check("rst_count", {24'd0, out_count}, 32'd0);
        check("rst_ovf",   {31'd0, out_ovf}, 32'd0);
        @(negedge clk) rst_ni = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 13; v++) begin
            for (int k = 0; k < vecs[v].n; k++) begin
                beat = (k == 0) ? vecs[v].d0 : ((k == 1) ? vecs[v].d1 : vecs[v].d2);
                send(beat, (k == vecs[v].n - 1));
            end
            check({vecs[v].name, "_valid"}, {31'd0, out_valid}, 32'd1);
            check({vecs[v].name, "_data"},  {16'd0, out_data}, {16'd0, vecs[v].exp_data});
            check({vecs[v].name, "_count"}, {24'd0, out_count}, {24'd0, vecs[v].exp_cnt});
            check({vecs[v].name, "_ovf"},   {31'd0, out_ovf}, 32'd0);
            @(posedge clk); #1;
            check({vecs[v].name, "_drain"}, {31'd0, out_valid}, 32'd0);
        end

        // Reset in the middle of a job
        send(16'h3C00, 1'b0);
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk) rst_ni = 1'b1;
        @(posedge clk); #1;
        send(16'h4000, 1'b1);
        check("post_rst_data", {16'd0, out_data}, 32'h4000);
        check("post_rst_count", {24'd0, out_count}, 32'd1);
        @(posedge clk); #1;

        // Backpressure then simultaneous drain and load
        out_ready = 1'b0;
        send(16'h3C00, 1'b0);
        send(16'h3C00, 1'b1);
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        check("bp_data", {16'd0, out_data}, 32'h4000);
        in_valid = 1'b1; in_data = 16'h4400; in_last = 1'b1;
        #1;
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check("bp_hold_data", {16'd0, out_data}, 32'h4000);
        check("bp_hold_count", {24'd0, out_count}, 32'd2);
        check("bp_hold_busy", {31'd0, busy}, 32'd0);
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_up", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        check("b2b_valid", {31'd0, out_valid}, 32'd1);
        check("b2b_data", {16'd0, out_data}, 32'h4400);
        check("b2b_count", {24'd0, out_count}, 32'd1);
        @(posedge clk); #1;
        check("b2b_drain", {31'd0, out_valid}, 32'd0);

        // Clear discards the partial sum and blocks the beat
        send(16'h3C00, 1'b0);
        send(16'h3C00, 1'b0);
        clear = 1'b1; in_valid = 1'b1; in_data = 16'h3C00; in_last = 1'b1;
        #1;
        check("clr_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        check("clr_busy", {31'd0, busy}, 32'd0);
        check("clr_no_out", {31'd0, out_valid}, 32'd0);
        send(16'h4500, 1'b1);
        check("clr_next_data", {16'd0, out_data}, 32'h4500);
        check("clr_next_count", {24'd0, out_count}, 32'd1);
        @(posedge clk); #1;

        // Count saturation on the narrow-counter instance
        for (int k = 0; k < 5; k++) begin
            send_sat(16'h3C00, (k == 4));
        end
        check("sat_valid", {31'd0, s_out_valid}, 32'd1);
        check("sat_count", {30'd0, s_out_count}, 32'd3);
        check("sat_ovf", {31'd0, s_out_ovf}, 32'd1);
        check("sat_data", {16'd0, s_out_data}, 32'h4500);
        for (int k = 0; k < 3; k++) begin
            send_sat(16'h3C00, (k == 2));
        end
        check("nosat_count", {30'd0, s_out_count}, 32'd3);
        check("nosat_ovf", {31'd0, s_out_ovf}, 32'd0);
        check("nosat_data", {16'd0, s_out_data}, 32'h4200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
